// File: rtl/divider.sv
// rtl/divider.sv - iterative radix-2 restoring divider (one quotient bit per cycle)
// Define DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             val,
    output logic             busy,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             val_q, val_d;
    logic             busy_q, busy_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   r_ext;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nxt_r;
    logic [WIDTH-1:0] nxt_q;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

`ifdef DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic overflow_q, overflow_d;
    logic sign_q_q, sign_q_d;
    logic sign_r_q, sign_r_d;
    logic ovf_case;

    assign mag1     = op1[WIDTH-1] ? -op1 : op1;
    assign mag2     = op2[WIDTH-1] ? -op2 : op2;
    assign ovf_case = (op1 == MIN_VAL) && (op2 == '1);
    assign fin_q    = sign_q_q ? -nxt_q : nxt_q;
    assign fin_r    = sign_r_q ? -nxt_r : nxt_r;
    assign overflow = overflow_q;
`else
    assign mag1     = op1;
    assign mag2     = op2;
    assign fin_q    = nxt_q;
    assign fin_r    = nxt_r;
    assign overflow = 1'b0;
`endif

    // One restoring step: trial-subtract the divisor from the shifted partial remainder.
    assign r_ext = {r_q, q_q[WIDTH-1]};
    assign diff  = r_ext - {1'b0, dvs_q};
    assign nxt_r = diff[WIDTH] ? r_ext[WIDTH-1:0] : diff[WIDTH-1:0];
    assign nxt_q = {q_q[WIDTH-2:0], ~diff[WIDTH]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        r_d        = r_q;
        dvs_d      = dvs_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        val_d      = val_q;
        busy_d     = busy_q;
        div_zero_d = div_zero_q;
`ifdef DIVIDER_SIGNED_EN
        overflow_d = overflow_q;
        sign_q_d   = sign_q_q;
        sign_r_d   = sign_r_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    q_d        = mag1;
                    dvs_d      = mag2;
                    r_d        = '0;
                    cnt_d      = CW'(WIDTH);
                    val_d      = 1'b0;
                    div_zero_d = 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    overflow_d = 1'b0;
                    sign_q_d   = op1[WIDTH-1] ^ op2[WIDTH-1];
                    sign_r_d   = op1[WIDTH-1];
`endif
                    if (op2 == '0) begin
                        quot_d     = '1;
                        rem_d      = op1;
                        div_zero_d = 1'b1;
                        val_d      = 1'b1;
`ifdef DIVIDER_SIGNED_EN
                    end else if (ovf_case) begin
                        quot_d     = MIN_VAL;
                        rem_d      = '0;
                        overflow_d = 1'b1;
                        val_d      = 1'b1;
`endif
                    end else begin
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                q_d   = nxt_q;
                r_d   = nxt_r;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = fin_q;
                    rem_d   = fin_r;
                    val_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            dvs_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            val_q      <= 1'b0;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            overflow_q <= 1'b0;
            sign_q_q   <= 1'b0;
            sign_r_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            r_q        <= r_d;
            dvs_q      <= dvs_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            val_q      <= val_d;
            busy_q     <= busy_d;
            div_zero_q <= div_zero_d;
`ifdef DIVIDER_SIGNED_EN
            overflow_q <= overflow_d;
            sign_q_q   <= sign_q_d;
            sign_r_q   <= sign_r_d;
`endif
        end
    end

    assign quot     = quot_q;
    assign rem      = rem_q;
    assign val      = val_q;
    assign busy     = busy_q;
    assign div_zero = div_zero_q;

endmodule
